// File: rtl/cond_pkg.sv
// cond_pkg: shared types and constants for the conditional-execution unit.
//   cond_t      - the 16 ARM condition codes (EQ..AL, plus the never-true 1111)
//   N/Z/C/V_BIT - bit positions of the flags inside a 4-bit NZCV vector
//   it_state_t  - IT block tracking state
//   slot_cond() - effective condition of one IT slot
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } it_state_t;

  // An else slot inverts the base condition through its low bit. Bases AL and
  // 1111 have no inverse: AL stays always-true and 1111 stays never-true, so
  // the base is used unchanged for every slot.
  function automatic cond_t slot_cond(input logic [3:0] base, input logic is_else);
    if (base[3:1] == 3'b111) return cond_t'(base);
    return cond_t'({base[3:1], base[0] ^ is_else});
  endfunction

endpackage

// File: rtl/cond_eval.sv
// cond_eval: combinational ARM condition-code check.
//   cond    - condition code to evaluate
//   flags   - NZCV flag vector
//   execute - 1 when the condition holds; 1111 always gives 0
module cond_eval
  import cond_pkg::*;
(
  input  cond_t       cond,
  input  logic [3:0]  flags,
  output logic        execute
);

  logic n, z, c, v;
  logic pair_true;

  assign n = flags[N_BIT];
  assign z = flags[Z_BIT];
  assign c = flags[C_BIT];
  assign v = flags[V_BIT];

  // Codes come in pairs {2k, 2k+1}; the odd member is the inverse of the even
  // one, so only the even test is spelled out and cond[0] inverts it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    pair_true = 1'b0;
    execute   = 1'b0;
    case (cond[3:1])
      3'b000:  pair_true = z;                  // EQ / NE
      3'b001:  pair_true = c;                  // CS / CC
      3'b010:  pair_true = n;                  // MI / PL
      3'b011:  pair_true = v;                  // VS / VC
      3'b100:  pair_true = c & ~z;             // HI / LS
      3'b101:  pair_true = (n == v);           // GE / LT
      3'b110:  pair_true = ~z & (n == v);      // GT / LE
      default: pair_true = 1'b1;               // AL / 1111
    endcase

    if (cond == COND_NV)      execute = 1'b0;
    else if (cond == COND_AL) execute = 1'b1;
    else                      execute = pair_true ^ cond[0];
  end

endmodule

// File: rtl/flopenr.sv
// flopenr: enabled register with synchronous active-high reset.
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears q to zero
//   en    - load d into q when high
//   d, q  - WIDTH-bit data in / registered data out
module flopenr #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cond_it_unit.sv
// cond_it_unit: NZCV flag register, per-instruction condition check and
// If-Then block predication, gating the decoder's write enables.
//   clock, reset                 - rising-edge clock, synchronous active-high reset
//   instr_valid                  - instruction present; consumes one IT slot
//   condition                    - instruction cond field (ignored inside an IT block)
//   alu_flags                    - {N,Z,C,V} from the ALU
//   potential_*                  - ungated decoder enables
//   it_start/it_first_cond/it_mask/it_length - IT instruction fields
//   program_counter_source, register_write, memory_write, flag_write - gated enables
//   flags                        - registered NZCV
//   conditional_execution        - condition check result this cycle
//   in_it_block                  - an IT block is active
//   it_fault                     - one-cycle pulse after an illegal IT event
module cond_it_unit
  import cond_pkg::*;
#(
  parameter int IT_MAX_LEN = 4,
  parameter int LEN_W      = $clog2(IT_MAX_LEN + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [3:0]            condition,
  input  logic [3:0]            alu_flags,
  input  logic [1:0]            potential_flag_write,
  input  logic                  potential_program_counter,
  input  logic                  potential_register_write,
  input  logic                  potential_memory_write,
  input  logic                  it_start,
  input  logic [3:0]            it_first_cond,
  input  logic [IT_MAX_LEN-1:0] it_mask,
  input  logic [LEN_W-1:0]      it_length,
  output logic                  program_counter_source,
  output logic                  register_write,
  output logic                  memory_write,
  output logic [1:0]            flag_write,
  output logic [3:0]            flags,
  output logic                  conditional_execution,
  output logic                  in_it_block,
  output logic                  it_fault
);

  localparam int              SLOT_W  = (IT_MAX_LEN > 1) ? $clog2(IT_MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(IT_MAX_LEN);

  it_state_t             state_q, state_d;
  logic [3:0]            base_q, base_d;
  logic [IT_MAX_LEN-1:0] mask_q, mask_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic                  fault_q, fault_d;
  logic [3:0]            flags_q;

  cond_t eff_cond;
  logic  slot_else;
  logic  exec_gate;
  logic  length_ok;
  logic  else_in_len;

  // ---------------- state register ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      remaining_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      remaining_q <= remaining_d;
      fault_q     <= fault_d;
    end
  end

  // NOTE: base and mask are only read while ACTIVE, and entering ACTIVE
  // always loads them, so they carry no reset.
  always_ff @(posedge clock) begin
    base_q <= base_d;
    mask_q <= mask_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    length_ok   = (it_length != '0) && (it_length <= MAX_LEN);
    else_in_len = 1'b0;
    for (int i = 1; i < IT_MAX_LEN; i++) begin
      if ((LEN_W'(i) < it_length) && it_mask[i]) else_in_len = 1'b1;
    end

    state_d     = state_q;
    base_d      = base_q;
    mask_d      = mask_q;
    slot_d      = slot_q;
    remaining_d = remaining_q;
    fault_d     = 1'b0;

    if (instr_valid) begin
      case (state_q)
        IDLE: begin
          if (it_start) begin
            if (length_ok) begin
              state_d     = ACTIVE;
              base_d      = it_first_cond;
              mask_d      = it_mask;
              slot_d      = '0;
              remaining_d = it_length;
              // Loaded anyway, but flagged: 1111 never executes, AL cannot
              // express an else slot.
              fault_d     = (it_first_cond == COND_NV) ||
                            ((it_first_cond == COND_AL) && else_in_len);
            end else begin
              fault_d = 1'b1;
            end
          end
        end
        default: begin // ACTIVE
          // A nested IT is not honoured; it just uses up its slot.
          fault_d     = it_start;
          slot_d      = slot_q + SLOT_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          // A taken branch leaves the block just like the final slot does.
          if ((remaining_q == LEN_W'(1)) || program_counter_source) begin
            state_d     = IDLE;
            slot_d      = '0;
            remaining_d = '0;
          end
        end
      endcase
    end
  end

  // ---------------- output logic ----------------
  always_comb begin
    // Slot 0 is always a "then" slot whatever mask bit 0 says.
    slot_else = (slot_q != '0) && mask_q[slot_q];
    eff_cond  = (state_q == ACTIVE) ? slot_cond(base_q, slot_else)
                                    : cond_t'(condition);
  end

  cond_eval u_cond_eval (
    .cond    (eff_cond),
    .flags   (flags_q),
    .execute (conditional_execution)
  );

  always_comb begin
    exec_gate              = conditional_execution & instr_valid;
    program_counter_source = potential_program_counter & exec_gate;
    register_write         = potential_register_write  & exec_gate;
    memory_write           = potential_memory_write    & exec_gate;
    flag_write             = potential_flag_write & {2{exec_gate}};
  end

  // Flags are split in two independently written groups: N,Z and C,V.
  flopenr #(.WIDTH(2)) u_flags_nz (
    .clk   (clock),
    .reset (reset),
    .en    (flag_write[1]),
    .d     (alu_flags[N_BIT:Z_BIT]),
    .q     (flags_q[N_BIT:Z_BIT])
  );

  flopenr #(.WIDTH(2)) u_flags_cv (
    .clk   (clock),
    .reset (reset),
    .en    (flag_write[0]),
    .d     (alu_flags[C_BIT:V_BIT]),
    .q     (flags_q[C_BIT:V_BIT])
  );

  assign flags       = flags_q;
  assign in_it_block = (state_q == ACTIVE);
  assign it_fault    = fault_q;

endmodule

// File: tb/tb_cond_it_unit.sv
// tb_cond_it_unit: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a queue-based model.
module tb_cond_it_unit;

  localparam int IT_MAX_LEN = 4;
  localparam int LEN_W      = $clog2(IT_MAX_LEN + 1);

  logic                  clock;
  logic                  reset;
  logic                  instr_valid;
  logic [3:0]            condition;
  logic [3:0]            alu_flags;
  logic [1:0]            potential_flag_write;
  logic                  potential_program_counter;
  logic                  potential_register_write;
  logic                  potential_memory_write;
  logic                  it_start;
  logic [3:0]            it_first_cond;
  logic [IT_MAX_LEN-1:0] it_mask;
  logic [LEN_W-1:0]      it_length;
  logic                  program_counter_source;
  logic                  register_write;
  logic                  memory_write;
  logic [1:0]            flag_write;
  logic [3:0]            flags;
  logic                  conditional_execution;
  logic                  in_it_block;
  logic                  it_fault;

  cond_it_unit #(.IT_MAX_LEN(IT_MAX_LEN)) dut (
    .clock                     (clock),
    .reset                     (reset),
    .instr_valid               (instr_valid),
    .condition                 (condition),
    .alu_flags                 (alu_flags),
    .potential_flag_write      (potential_flag_write),
    .potential_program_counter (potential_program_counter),
    .potential_register_write  (potential_register_write),
    .potential_memory_write    (potential_memory_write),
    .it_start                  (it_start),
    .it_first_cond             (it_first_cond),
    .it_mask                   (it_mask),
    .it_length                 (it_length),
    .program_counter_source    (program_counter_source),
    .register_write            (register_write),
    .memory_write              (memory_write),
    .flag_write                (flag_write),
    .flags                     (flags),
    .conditional_execution     (conditional_execution),
    .in_it_block               (in_it_block),
    .it_fault                  (it_fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM condition table written straight from its definitions.
  function automatic bit ref_cond(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model: an active IT block is a queue of the conditions still to apply,
  // one popped per valid instruction; empty queue means no block.
  logic [3:0] m_flags;
  logic [3:0] m_q[$];
  logic       m_fault;

  always @(posedge clock) begin : model
    bit         e, nf, has_else, is_else;
    logic [3:0] cur;
    if (reset) begin
      m_flags = 4'h0;
      m_q.delete();
      m_fault = 1'b0;
    end else if (instr_valid) begin
      cur = (m_q.size() != 0) ? m_q[0] : condition;
      e   = ref_cond(cur, m_flags);
      nf  = 1'b0;
      if (m_q.size() == 0) begin
        if (it_start) begin
          if (int'(it_length) >= 1 && int'(it_length) <= IT_MAX_LEN) begin
            has_else = 1'b0;
            for (int i = 0; i < int'(it_length); i++) begin
              is_else = (i > 0) && it_mask[i];
              if (is_else) has_else = 1'b1;
              if (it_first_cond == 4'hF)      m_q.push_back(4'hF);
              else if (it_first_cond == 4'hE) m_q.push_back(4'hE);
              else                            m_q.push_back(it_first_cond ^ {3'b000, is_else});
            end
            nf = (it_first_cond == 4'hF) || ((it_first_cond == 4'hE) && has_else);
          end else begin
            nf = 1'b1;
          end
        end
      end else begin
        void'(m_q.pop_front());
        if (it_start) nf = 1'b1;
        if (potential_program_counter && e) m_q.delete();
      end
      if (potential_flag_write[1] && e) m_flags[3:2] = alu_flags[3:2];
      if (potential_flag_write[0] && e) m_flags[1:0] = alu_flags[1:0];
      m_fault = nf;
    end else begin
      m_fault = 1'b0;
    end
  end

  always @(negedge clock) begin : compare
    bit         e;
    logic [3:0] cur;
    if (cmp_en) begin
      cur = (m_q.size() != 0) ? m_q[0] : condition;
      e   = ref_cond(cur, m_flags);
      check("cond_exec", conditional_execution, e);
      check("pc_src",    program_counter_source, potential_program_counter & e & instr_valid);
      check("reg_wr",    register_write, potential_register_write & e & instr_valid);
      check("mem_wr",    memory_write, potential_memory_write & e & instr_valid);
      check("flag_wr",   flag_write, potential_flag_write & {2{e & instr_valid}});
      check("flags",     flags, m_flags);
      check("in_it",     in_it_block, m_q.size() != 0);
      check("it_fault",  it_fault, m_fault);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid               = 1'b0;
    condition                 = 4'h0;
    alu_flags                 = 4'h0;
    potential_flag_write      = 2'b00;
    potential_program_counter = 1'b0;
    potential_register_write  = 1'b0;
    potential_memory_write    = 1'b0;
    it_start                  = 1'b0;
    it_first_cond             = 4'h0;
    it_mask                   = '0;
    it_length                 = '0;
  endtask

  // Only used outside an IT block: an AL instruction writing both groups.
  task automatic set_flags(input logic [3:0] f);
    clear_inputs();
    instr_valid          = 1'b1;
    condition            = 4'hE;
    potential_flag_write = 2'b11;
    alu_flags            = f;
    tick();
    clear_inputs();
  endtask

  task automatic it_instr(input logic [3:0] base, input logic [IT_MAX_LEN-1:0] mask,
                          input logic [LEN_W-1:0] len);
    clear_inputs();
    instr_valid   = 1'b1;
    condition     = 4'hE;
    it_start      = 1'b1;
    it_first_cond = base;
    it_mask       = mask;
    it_length     = len;
    tick();
    clear_inputs();
  endtask

  initial begin : stim
    bit [5:0] vpat;
    clear_inputs();
    reset = 1'b1;
    tick();
    cmp_en = 1'b1;
    tick();
    #2;
    check("rst_flags", flags, 4'h0);
    check("rst_in_it", in_it_block, 1'b0);
    check("rst_fault", it_fault, 1'b0);
    reset = 1'b0;

    // Z set, EQ passes and NE blocks every enable.
    set_flags(4'b0100);
    #2 check("flags_z", flags, 4'b0100);
    instr_valid = 1'b1; condition = 4'h0;
    potential_program_counter = 1'b1; potential_register_write = 1'b1;
    potential_memory_write = 1'b1; potential_flag_write = 2'b11; alu_flags = 4'b0100;
    #2;
    check("eq_pc", program_counter_source, 1'b1);
    check("eq_rw", register_write, 1'b1);
    check("eq_mw", memory_write, 1'b1);
    check("eq_fw", flag_write, 2'b11);
    condition = 4'h1;
    #1;
    check("ne_pc", program_counter_source, 1'b0);
    check("ne_rw", register_write, 1'b0);
    check("ne_mw", memory_write, 1'b0);
    check("ne_fw", flag_write, 2'b00);
    tick();

    // ITTE EQ with Z=1: then, then, else.
    it_instr(4'h0, 4'b0100, 3);
    #2 check("itte_in_it", in_it_block, 1'b1);
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      instr_valid = 1'b1; condition = 4'h1; potential_register_write = 1'b1;
      #2 check("itte_rw", register_write, k < 2);
      tick();
    end
    clear_inputs();
    #2 check("itte_done", in_it_block, 1'b0);

    // Length-4 block with two bubbles after slot 0.
    it_instr(4'h0, 4'b0000, 4);
    vpat = 6'b111001;
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      instr_valid = vpat[k]; potential_register_write = 1'b1;
      #2;
      check("bub_rw", register_write, vpat[k]);
      check("bub_in_it", in_it_block, 1'b1);
      tick();
    end
    clear_inputs();
    #2 check("bub_done", in_it_block, 1'b0);

    // Taken branch in slot 1 ends the block.
    it_instr(4'h0, 4'b0000, 4);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b1; potential_program_counter = 1'b1;
    #2 check("br_pc", program_counter_source, 1'b1);
    tick();
    clear_inputs();
    #2 check("br_exit", in_it_block, 1'b0);
    instr_valid = 1'b1; condition = 4'h1; potential_register_write = 1'b1;
    #2 check("br_ne_rw", register_write, 1'b0);
    condition = 4'h0;
    #1 check("br_eq_rw", register_write, 1'b1);
    tick();
    clear_inputs();

    // Fault cases.
    it_instr(4'h0, 4'b0000, 0);
    #2 check("len0_fault", it_fault, 1'b1);
    check("len0_idle", in_it_block, 1'b0);
    tick();
    #2 check("fault_clr", it_fault, 1'b0);
    it_instr(4'h0, 4'b0000, 5);
    #2 check("len5_fault", it_fault, 1'b1);
    check("len5_idle", in_it_block, 1'b0);
    it_instr(4'h0, 4'b0000, 2);
    #2 check("it2_fault", it_fault, 1'b0);
    check("it2_in_it", in_it_block, 1'b1);
    instr_valid = 1'b1; it_start = 1'b1; it_first_cond = 4'h1; it_length = 2;
    tick();
    clear_inputs();
    #2 check("nest_fault", it_fault, 1'b1);
    check("nest_in_it", in_it_block, 1'b1);
    instr_valid = 1'b1;
    tick();
    clear_inputs();
    #2 check("nest_done", in_it_block, 1'b0);
    it_instr(4'hF, 4'b0000, 2);
    #2 check("nv_fault", it_fault, 1'b1);
    for (int k = 0; k < 2; k++) begin
      instr_valid = 1'b1; potential_register_write = 1'b1;
      #2 check("nv_rw", register_write, 1'b0);
      tick();
      clear_inputs();
    end
    #2 check("nv_done", in_it_block, 1'b0);
    it_instr(4'hE, 4'b0010, 2);
    #2 check("al_else_fault", it_fault, 1'b1);
    for (int k = 0; k < 2; k++) begin
      instr_valid = 1'b1; potential_register_write = 1'b1;
      #2 check("al_rw", register_write, 1'b1);
      tick();
      clear_inputs();
    end

    // Reset in the middle of a block with all flags set.
    set_flags(4'hF);
    #2 check("flags_f", flags, 4'hF);
    it_instr(4'h1, 4'b0000, 4);
    #2 check("pre_rst_in_it", in_it_block, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #2;
    check("mid_rst_flags", flags, 4'h0);
    check("mid_rst_in_it", in_it_block, 1'b0);
    check("mid_rst_fault", it_fault, 1'b0);

    // Randomized traffic, checked by the compare process.
    for (int k = 0; k < 4000; k++) begin
      reset                     = ($urandom_range(0, 299) == 0);
      instr_valid               = ($urandom_range(0, 9) < 8);
      condition                 = 4'($urandom);
      alu_flags                 = 4'($urandom);
      potential_flag_write      = 2'($urandom);
      potential_program_counter = ($urandom_range(0, 7) == 0);
      potential_register_write  = 1'($urandom);
      potential_memory_write    = 1'($urandom);
      it_start                  = ($urandom_range(0, 5) == 0);
      it_first_cond             = 4'($urandom);
      it_mask                   = IT_MAX_LEN'($urandom);
      it_length                 = LEN_W'($urandom_range(0, 5));
      tick();
    end
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
